spi_mem_arbiter: RTL and testbench
==================================

# spi_mem_arbiter

Shares the single serial-flash read engine between the CPU instruction-fetch port and the data-load port. Requests are arbitrated round-robin and serialised as one address per engine transaction. A one-entry instruction buffer serves repeated fetches without SPI traffic, and an optional next-line prefetch is available. Sits between the CPU core and the SPI program-memory read engine.

## Interface
Parameters:
- ADDR_W, 16, flash word-address width
- DATA_W, 16, word width returned by the engine

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; level, held until if_valid
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_valid  out  1  one-cycle pulse: if_data valid
- if_data  out  DATA_W  fetched instruction; held until next if_valid
- d_req  in  1  data-read request; level, held until d_valid
- d_addr  in  ADDR_W  data address; stable while d_req
- d_valid  out  1  one-cycle pulse: d_data valid
- d_data  out  DATA_W  read data; held until next d_valid
- eng_start  out  1  one-cycle pulse launching an engine read
- eng_addr  out  ADDR_W  engine address; stable from eng_start until eng_done
- eng_done  in  1  one-cycle pulse: eng_data valid
- eng_data  in  DATA_W  engine read result
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP, PF_WAIT (PF_WAIT exists only with the macro).
- Instruction buffer: buf_addr, buf_data, buf_valid. It is written by every completed fetch or prefetch, and never by data reads.
- IDLE, evaluated in this order:
  - if_req and buf_valid and if_addr==buf_addr: fetch hit. Go to RESP with owner=IF; no engine traffic.
  - Else if exactly one of d_req or (if_req miss) is pending: grant it.
  - Else if both are pending: grant the port opposite to last_grant. last_grant resets to IF, so data wins the first tie.
  - On grant: latch owner and address, update last_grant, go to ISSUE.
- ISSUE: assert eng_start for one cycle with eng_addr = latched address, then go to WAIT.
- WAIT: on eng_done, capture eng_data. If owner=IF, also update the buffer (buf_valid=1). Go to RESP.
- RESP: pulse the owner's valid with the owner's data, then go to IDLE (or PF_WAIT, see Configuration).
- Requester drops its req before completion: the engine transaction still completes, the buffer is still updated for IF, and the valid pulse is still emitted. The requester ignores it.
- A hit is only checked in IDLE. A fetch that arrives during an engine transaction waits.
- Address arithmetic is modulo 2^ADDR_W: prefetch of all-ones wraps to 0.
- Reset mid-transaction:
  - All outputs return to reset values immediately.
  - buf_valid is cleared.
  - A later eng_done is ignored because the state is IDLE.
- Reset values: if_valid=0, d_valid=0, if_data=0, d_data=0, eng_start=0, eng_addr=0, busy=0, buf_valid=0, last_grant=IF.

## Timing
- Hit: if_req seen in IDLE at cycle N → if_valid at N+1.
- Miss: grant at N → eng_start at N+1 → eng_done at M → valid at M+1. Total added latency is 2 cycles over the engine.
- Back-to-back operation: the earliest next grant is the cycle after RESP, one idle cycle.
- eng_done outside WAIT/PF_WAIT is ignored.
- Only one engine transaction is ever outstanding.

## Configuration
- SPI_ARB_PREFETCH_EN defined:
  - After an IF RESP from a miss, if d_req is low, issue eng_start for buf_addr+1 and enter PF_WAIT.
  - On eng_done in PF_WAIT, load the buffer with that address and data, then go to IDLE.
  - Requests arriving during PF_WAIT wait. The prefetch is never aborted, and a fetch of the prefetched address then hits.
  - If d_req is high at RESP, the prefetch is skipped.
- Not defined: RESP always goes to IDLE. PF_WAIT and its logic are absent, and there is no speculative SPI traffic.

## Structure
- Shared package spi_mem_pkg holds:
  - state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, RESP=3, PF_WAIT=4)
  - owner encoding (IF=0, D=1)
  - SPI_READ_CMD = 8'h03 and the default address/data widths
- Natural sub-module: spi_rr_arb2, a 2-input round-robin grant with a last_grant register. Hit logic and the FSM stay in the top.

## Test plan
- Reset: hold rst_n=0 with eng_done pulsing → all outputs 0, busy=0, no eng_start.
- Fetch miss then hit:
  - if_req at 0x0010, engine returns 0xBEEF after 40 cycles → eng_addr=0x0010, if_valid 1 cycle after eng_done with if_data=0xBEEF.
  - Repeat fetch 0x0010 → if_valid next cycle with 0xBEEF and no eng_start.
- Tie arbitration: if_req(0x0020) and d_req(0x1000) rise together after reset:
  - first eng_addr=0x1000, then 0x0020
  - next tie grants data again (last_grant=IF).
- Data read does not pollute the buffer: fetch 0x0005 miss, d_req 0x0005 with engine returning 0x1234, then fetch 0x0005 → hit with the original fetch data and no eng_start.
- Reset mid-WAIT: assert rst_n=0 between eng_start and eng_done → no valid pulse. After release, fetch of the old address misses.
- With SPI_ARB_PREFETCH_EN: fetch 0xFFFF miss → eng_start 0xFFFF, then eng_start 0x0000 (wrap). Fetch 0x0000 after PF_WAIT → 1-cycle hit. With d_req high at RESP → no prefetch.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared encodings for the SPI program-memory arbiter.
// Optional next-line prefetch state is present only with SPI_ARB_PREFETCH_EN.
package spi_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  localparam logic [7:0] SPI_READ_CMD = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3
`ifdef SPI_ARB_PREFETCH_EN
    ,
    ST_PF_WAIT = 3'd4
`endif
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-input round-robin grant. On a tie the port opposite to the last grant wins.
module spi_rr_arb2
  import spi_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   if_pending,
  input  logic   d_pending,
  input  logic   accept,
  output owner_t grant,
  output logic   grant_valid
);

  owner_t last_grant;

  // Pick the winner for this cycle.
  always_comb begin
    grant_valid = if_pending | d_pending;
    grant       = OWN_IF;
    if (if_pending && d_pending) begin
      grant = (last_grant == OWN_IF) ? OWN_D : OWN_IF;
    end else if (d_pending) begin
      grant = OWN_D;
    end
  end

  // Remember the last accepted grant; reset value makes data win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= OWN_IF;
    end else if (accept && grant_valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Arbitrates CPU fetch and data-load reads onto one SPI flash read engine,
// with a one-entry instruction buffer.
// Define SPI_ARB_PREFETCH_EN to enable next-line prefetch after a fetch miss.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_data,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_data,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              buf_valid;
  logic              hit;
  owner_t            grant;
  logic              grant_valid;
`ifdef SPI_ARB_PREFETCH_EN
  logic              miss_q;
`endif

  assign hit      = if_req && buf_valid && (if_addr == buf_addr);
  assign eng_addr = addr_q;
  assign busy     = (state_q != ST_IDLE);

  spi_rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_pending  (if_req && !hit),
    .d_pending   (d_req),
    .accept      ((state_q == ST_IDLE) && !hit),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and per-state output pulses.
  always_comb begin
    state_d   = state_q;
    eng_start = 1'b0;
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit)              state_d = ST_RESP;
        else if (grant_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        eng_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        if_valid = (owner_q == OWN_IF);
        d_valid  = (owner_q == OWN_D);
        state_d  = ST_IDLE;
`ifdef SPI_ARB_PREFETCH_EN
        if (owner_q == OWN_IF && miss_q && !d_req) begin
          eng_start = 1'b1;
          state_d   = ST_PF_WAIT;
        end
`endif
      end
`ifdef SPI_ARB_PREFETCH_EN
      ST_PF_WAIT: begin
        if (eng_done) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch grant, capture engine data, maintain the instruction buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
      if_data   <= '0;
      d_data    <= '0;
`ifdef SPI_ARB_PREFETCH_EN
      miss_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            owner_q <= OWN_IF;
            if_data <= buf_data;
`ifdef SPI_ARB_PREFETCH_EN
            miss_q  <= 1'b0;
`endif
          end else if (grant_valid) begin
            owner_q <= grant;
            addr_q  <= (grant == OWN_IF) ? if_addr : d_addr;
`ifdef SPI_ARB_PREFETCH_EN
            miss_q  <= 1'b1;
`endif
          end
        end
        ST_WAIT: begin
          if (eng_done) begin
            if (owner_q == OWN_IF) begin
              if_data   <= eng_data;
              buf_addr  <= addr_q;
              buf_data  <= eng_data;
              buf_valid <= 1'b1;
`ifdef SPI_ARB_PREFETCH_EN
              // Advance to the next line now so eng_addr is already correct
              // when RESP launches the prefetch; harmless if it is skipped.
              addr_q    <= addr_q + ADDR_W'(1);
`endif
            end else begin
              d_data <= eng_data;
            end
          end
        end
`ifdef SPI_ARB_PREFETCH_EN
        ST_PF_WAIT: begin
          if (eng_done) begin
            buf_addr  <= addr_q;
            buf_data  <= eng_data;
            buf_valid <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter with a behavioural read engine and
// per-port expected-data queues.
module tb_spi_mem_arbiter;

`ifdef SPI_ARB_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, eng_done;
  logic [15:0] if_addr, d_addr, eng_data;
  logic        if_valid, d_valid, eng_start, busy;
  logic [15:0] if_data, d_data, eng_addr;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int if_seen = 0;
  int d_seen = 0;
  logic [15:0] addr_log[$];
  logic [15:0] exp_if[$];
  logic [15:0] exp_d[$];

  int          eng_lat = 8;
  bit          ovr_en = 1'b0;
  logic [15:0] ovr_addr = '0;
  logic [15:0] ovr_data = '0;

  spi_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
    .d_req(d_req), .d_addr(d_addr), .d_valid(d_valid), .d_data(d_data),
    .eng_start(eng_start), .eng_addr(eng_addr), .eng_done(eng_done),
    .eng_data(eng_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Log every engine launch.
  always @(posedge clk) begin
    if (eng_start) begin
      start_cnt <= start_cnt + 1;
      addr_log.push_back(eng_addr);
    end
  end

  // Engine model: eng_done eng_lat cycles after eng_start; junk pulses during reset.
  initial begin
    logic [15:0] a;
    eng_done = 1'b0;
    eng_data = '0;
    repeat (4) begin
      @(negedge clk); eng_done = 1'b1; eng_data = 16'hFFFF;
      @(negedge clk); eng_done = 1'b0;
    end
    forever begin
      @(negedge clk);
      while (eng_start) begin
        a = eng_addr;
        repeat (eng_lat - 1) @(negedge clk);
        eng_data = (ovr_en && a == ovr_addr) ? ovr_data : mem_fn(a);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
      end
    end
  end

  // Scoreboard: compare every valid pulse with the oldest expected word.
  always @(negedge clk) begin
    logic [15:0] e;
    if (if_valid) begin
      if_seen++;
      total++;
      if (exp_if.size() == 0) begin
        bad++;
        $display("FAIL if_unexpected: got if_valid with data=%h, required no pulse", if_data);
      end else begin
        e = exp_if.pop_front();
        if (if_data !== e) begin
          bad++;
          $display("FAIL if_data: got %h, required %h", if_data, e);
        end
      end
    end
    if (d_valid) begin
      d_seen++;
      total++;
      if (exp_d.size() == 0) begin
        bad++;
        $display("FAIL d_unexpected: got d_valid with data=%h, required no pulse", d_data);
      end else begin
        e = exp_d.pop_front();
        if (d_data !== e) begin
          bad++;
          $display("FAIL d_data: got %h, required %h", d_data, e);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    total++;
    if (busy) begin
      bad++;
      $display("FAIL %s_idle: busy still %b after %0d cycles, required 0", nm, busy, n);
    end
  endtask

  // Single fetch; called at a negedge with the arbiter idle.
  task automatic fetch(input logic [15:0] a, input logic [15:0] e, input bit exp_hit,
                       input int exp_cyc, input string nm);
    int cyc = 0;
    int s0 = start_cnt;
    exp_if.push_back(e);
    if_addr = a; if_req = 1'b1;
    do begin @(negedge clk); cyc++; end while (!if_valid && cyc < 400);
    if_req = 1'b0;
    total++;
    if (!if_valid) begin
      bad++;
      $display("FAIL %s_timeout: no if_valid after %0d cycles", nm, cyc);
      void'(exp_if.pop_back());
    end
    total++;
    if (start_cnt - s0 != (exp_hit ? 0 : 1)) begin
      bad++;
      $display("FAIL %s_starts: got %0d eng_start, required %0d", nm, start_cnt - s0, exp_hit ? 0 : 1);
    end
    total++;
    if (cyc != exp_cyc) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", nm, cyc, exp_cyc);
    end
    if (!exp_hit) begin
      total++;
      if (addr_log.size() == 0 || addr_log[$] !== a) begin
        bad++;
        $display("FAIL %s_eng_addr: got %h, required %h", nm,
                 (addr_log.size() == 0) ? 16'hxxxx : addr_log[$], a);
      end
    end
    wait_idle(nm);
  endtask

  task automatic dread(input logic [15:0] a, input logic [15:0] e, input string nm);
    int cyc = 0;
    exp_d.push_back(e);
    d_addr = a; d_req = 1'b1;
    do begin @(negedge clk); cyc++; end while (!d_valid && cyc < 400);
    d_req = 1'b0;
    total++;
    if (!d_valid) begin
      bad++;
      $display("FAIL %s_timeout: no d_valid after %0d cycles", nm, cyc);
      void'(exp_d.pop_back());
    end
    wait_idle(nm);
  endtask

  // Raise both requests together and check engine address order.
  task automatic tie(input logic [15:0] ia, input logic [15:0] da, input logic [15:0] first,
                     input logic [15:0] second, input string nm);
    bit gi = 1'b0;
    bit gd = 1'b0;
    int n = 0;
    addr_log.delete();
    exp_if.push_back(mem_fn(ia));
    exp_d.push_back(mem_fn(da));
    if_addr = ia; d_addr = da; if_req = 1'b1; d_req = 1'b1;
    while (!(gi && gd) && n < 400) begin
      @(negedge clk); n++;
      if (if_valid) begin gi = 1'b1; if_req = 1'b0; end
      if (d_valid)  begin gd = 1'b1; d_req = 1'b0; end
    end
    total++;
    if (!(gi && gd)) begin
      bad++;
      $display("FAIL %s_timeout: if_done=%b d_done=%b, required both", nm, gi, gd);
      if_req = 1'b0; d_req = 1'b0;
    end
    total++;
    if (addr_log.size() < 2) begin
      bad++;
      $display("FAIL %s_order: got %0d engine launches, required 2", nm, addr_log.size());
    end else if (addr_log[0] !== first || addr_log[1] !== second) begin
      bad++;
      $display("FAIL %s_order: got %h,%h required %h,%h", nm, addr_log[0], addr_log[1], first, second);
    end
    wait_idle(nm);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({if_valid, d_valid, eng_start, busy} !== 4'b0) begin
        bad++;
        $display("FAIL reset_ctrl: got if_valid/d_valid/eng_start/busy=%b, required 0000",
                 {if_valid, d_valid, eng_start, busy});
      end
      total++;
      if ({if_data, d_data, eng_addr} !== 48'h0) begin
        bad++;
        $display("FAIL reset_data: got if_data=%h d_data=%h eng_addr=%h, required 0",
                 if_data, d_data, eng_addr);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (start_cnt != 0) begin
      bad++;
      $display("FAIL reset_starts: got %0d eng_start, required 0", start_cnt);
    end
  endtask

  task automatic test_fetch_miss_hit();
    eng_lat = 40;
    ovr_en = 1'b1; ovr_addr = 16'h0010; ovr_data = 16'hBEEF;
    fetch(16'h0010, 16'hBEEF, 1'b0, 41, "miss_0010");
    // With prefetch the buffer has moved on to 0x0011, so the repeat misses.
    fetch(16'h0010, 16'hBEEF, !PF, PF ? 41 : 1, "repeat_0010");
    ovr_en = 1'b0;
    eng_lat = 8;
  endtask

  task automatic test_tie();
    do_reset();
    tie(16'h0020, 16'h1000, 16'h1000, 16'h0020, "tie1");
    tie(16'h0030, 16'h1001, 16'h1001, 16'h0030, "tie2");
  endtask

  task automatic test_no_pollution();
    logic [15:0] h;
    do_reset();
    fetch(16'h0005, mem_fn(16'h0005), 1'b0, 9, "poll_fetch");
    h = PF ? 16'h0006 : 16'h0005;
    ovr_en = 1'b1; ovr_addr = h; ovr_data = 16'h1234;
    dread(h, 16'h1234, "poll_dread");
    ovr_en = 1'b0;
    fetch(h, mem_fn(h), 1'b1, 1, "poll_hit");
  endtask

  task automatic test_reset_mid_wait();
    int s0, n, seen0;
    logic [15:0] b;
    do_reset();
    fetch(16'h0040, mem_fn(16'h0040), 1'b0, 9, "rmw_prime");
    b = PF ? 16'h0041 : 16'h0040;
    eng_lat = 20;
    s0 = start_cnt; n = 0; seen0 = if_seen;
    if_addr = 16'h0050; if_req = 1'b1;
    do begin @(negedge clk); n++; end while (start_cnt == s0 && n < 50);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, eng_start, if_valid} !== 3'b0) begin
      bad++;
      $display("FAIL rmw_async: got busy/eng_start/if_valid=%b, required 000", {busy, eng_start, if_valid});
    end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    total++;
    if (if_seen != seen0) begin
      bad++;
      $display("FAIL rmw_no_valid: got %0d if_valid pulses, required 0", if_seen - seen0);
    end
    eng_lat = 8;
    fetch(b, mem_fn(b), 1'b0, 9, "rmw_refetch");
  endtask

`ifdef SPI_ARB_PREFETCH_EN
  task automatic test_prefetch_wrap();
    do_reset();
    addr_log.delete();
    fetch(16'hFFFF, mem_fn(16'hFFFF), 1'b0, 9, "pf_ffff");
    total++;
    if (addr_log.size() != 2 || addr_log[1] !== 16'h0000) begin
      bad++;
      $display("FAIL pf_wrap: got %0d launches last=%h, required 2 last=0000",
               addr_log.size(), addr_log[$]);
    end
    fetch(16'h0000, mem_fn(16'h0000), 1'b1, 1, "pf_hit");
  endtask

  task automatic test_prefetch_skip();
    bit gi = 1'b0;
    bit gd = 1'b0;
    int n = 0;
    do_reset();
    addr_log.delete();
    exp_if.push_back(mem_fn(16'h0100));
    exp_d.push_back(mem_fn(16'h2000));
    if_addr = 16'h0100; if_req = 1'b1;
    while (!(gi && gd) && n < 400) begin
      @(negedge clk); n++;
      if (n == 3) begin d_addr = 16'h2000; d_req = 1'b1; end
      if (if_valid) begin gi = 1'b1; if_req = 1'b0; end
      if (d_valid)  begin gd = 1'b1; d_req = 1'b0; end
    end
    total++;
    if (!(gi && gd)) begin
      bad++;
      $display("FAIL pf_skip_timeout: if_done=%b d_done=%b, required both", gi, gd);
      if_req = 1'b0; d_req = 1'b0;
    end
    wait_idle("pf_skip");
    total++;
    if (addr_log.size() != 2 || addr_log[0] !== 16'h0100 || addr_log[1] !== 16'h2000) begin
      bad++;
      $display("FAIL pf_skip_order: got %0d launches last=%h, required 0100,2000",
               addr_log.size(), addr_log[$]);
    end
    fetch(16'h0101, mem_fn(16'h0101), 1'b0, 9, "pf_skip_next");
  endtask
`else
  task automatic test_no_prefetch();
    do_reset();
    addr_log.delete();
    fetch(16'h0200, mem_fn(16'h0200), 1'b0, 9, "nopf_fetch");
    repeat (20) @(negedge clk);
    total++;
    if (addr_log.size() != 1) begin
      bad++;
      $display("FAIL nopf_traffic: got %0d engine launches, required 1", addr_log.size());
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; if_addr = '0; d_addr = '0;
    test_reset();
    test_fetch_miss_hit();
    test_tie();
    test_no_pollution();
    test_reset_mid_wait();
`ifdef SPI_ARB_PREFETCH_EN
    test_prefetch_wrap();
    test_prefetch_skip();
`else
    test_no_prefetch();
`endif
    repeat (5) @(negedge clk);
    total++;
    if (exp_if.size() != 0 || exp_d.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d if / %0d d responses outstanding, required 0",
               exp_if.size(), exp_d.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
